eth_pattern_gen_chk: RTL and testbench

Synthesizable XGMII test-pattern generator and self-synchronising loopback checker for the 10G PHY bring-up path. Drives `xgmii_txd/txc` into the PHY TX side and checks `xgmii_rxd/rxc` from the PHY RX side. It replaces fixed bench-side pattern loops with programmable table, counter and PRBS31 modes, lock tracking and error counters. It is usable in simulation and on hardware.

---
 rtl/eth_pattern_pkg.sv | 37 +++
 rtl/eth_pattern_prbs31.sv | 27 ++
 rtl/eth_pattern_gen_chk.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_eth_pattern_gen_chk.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pattern_pkg.sv
// Shared encodings and constants for the XGMII pattern generator/checker.
package eth_pattern_pkg;

  // cfg_mode encodings
  localparam logic [1:0] MODE_IDLE    = 2'd0;
  localparam logic [1:0] MODE_TABLE   = 2'd1;
  localparam logic [1:0] MODE_COUNTER = 2'd2;
  localparam logic [1:0] MODE_PRBS31  = 2'd3;

  // Checker FSM states
  localparam logic [1:0] CHK_HUNT   = 2'd0;
  localparam logic [1:0] CHK_VERIFY = 2'd1;
  localparam logic [1:0] CHK_LOCKED = 2'd2;

  // XGMII idle character
  localparam logic [7:0] IDLE_BYTE = 8'h07;

  // PRBS31 (x^31 + x^28 + 1) register length and taps
  localparam int PRBS_LEN    = 31;
  localparam int PRBS_TAP_HI = 30;
  localparam int PRBS_TAP_LO = 27;

  // Table preload list; each byte is replicated across the data word.
  // Indices past the list (and past the table depth) read as zero.
  function automatic logic [7:0] preload_byte(input int idx);
    case (idx)
      0:       return 8'hFF;
      1:       return 8'h00;
      2:       return 8'h55;
      3:       return 8'hAA;
      4:       return 8'hFE;
      5:       return 8'h07;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/eth_pattern_prbs31.sv
// Combinational PRBS31 advance: DATA_WIDTH steps per call, bit 0 of the word first.
module eth_pattern_prbs31
  import eth_pattern_pkg::*;
#(
  parameter int DATA_WIDTH = 64
)(
  input  logic [PRBS_LEN-1:0]   i_state,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [PRBS_LEN-1:0]   o_state
);

  // Unrolled LFSR steps; each new feedback bit becomes the next output bit
  always_comb begin
    logic [PRBS_LEN-1:0] w_s;
    logic                w_n;
    w_s    = i_state;
    w_n    = 1'b0;
    o_data = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      w_n       = w_s[PRBS_TAP_HI] ^ w_s[PRBS_TAP_LO];
      o_data[i] = w_n;
      w_s       = {w_s[PRBS_LEN-2:0], w_n};
    end
    o_state = w_s;
  end

endmodule

// File: rtl/eth_pattern_gen_chk.sv
// XGMII test-pattern generator and self-synchronising loopback checker.
//
// state  | meaning
// HUNT   | searching for a data word to seed the expected sequence
// VERIFY | counting consecutive matches toward lock, no errors counted
// LOCKED | every word compared; errors and words counted
module eth_pattern_gen_chk
  import eth_pattern_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int CTRL_WIDTH    = DATA_WIDTH / 8,
  parameter int PATTERN_DEPTH = 8,
  parameter int ADDR_WIDTH    = $clog2(PATTERN_DEPTH),
  parameter int LOCK_MATCHES  = 8,
  parameter int UNLOCK_ERRORS = 4,
  parameter int ERR_CNT_WIDTH = 16
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_enable,
  input  logic [1:0]               cfg_mode,
  input  logic [ADDR_WIDTH-1:0]    cfg_pat_last,
  input  logic                     cfg_pat_wr_en,
  input  logic [ADDR_WIDTH-1:0]    cfg_pat_wr_addr,
  input  logic [DATA_WIDTH-1:0]    cfg_pat_wr_data,
  input  logic                     cfg_clear,
  output logic [DATA_WIDTH-1:0]    xgmii_txd,
  output logic [CTRL_WIDTH-1:0]    xgmii_txc,
  input  logic [DATA_WIDTH-1:0]    xgmii_rxd,
  input  logic [CTRL_WIDTH-1:0]    xgmii_rxc,
  output logic                     chk_lock,
  output logic                     chk_error,
  output logic [ERR_CNT_WIDTH-1:0] chk_error_count,
  output logic [31:0]              chk_word_count
);

  localparam logic [DATA_WIDTH-1:0] IDLE_WORD = {CTRL_WIDTH{IDLE_BYTE}};
  localparam int MATCH_W  = $clog2(LOCK_MATCHES + 1);
  localparam int STREAK_W = $clog2(UNLOCK_ERRORS + 1);

  // cfg_pat_last cannot exceed DEPTH-1 because the depth is a power of two,
  // so the clamp is implicit in the address width.
  function automatic logic [ADDR_WIDTH-1:0] f_idx_next(input logic [ADDR_WIDTH-1:0] cur,
                                                       input logic [ADDR_WIDTH-1:0] last);
    return (cur >= last) ? '0 : cur + ADDR_WIDTH'(1);
  endfunction

  logic [DATA_WIDTH-1:0] r_table [PATTERN_DEPTH];
  logic [1:0]            r_prev_mode;
  logic                  r_prev_enable;
  logic [DATA_WIDTH-1:0] r_txd;
  logic [CTRL_WIDTH-1:0] r_txc;
  logic [ADDR_WIDTH-1:0] r_gen_idx;
  logic [DATA_WIDTH-1:0] r_gen_cnt;
  logic [PRBS_LEN-1:0]   r_gen_prbs;

  logic [1:0]               r_chk_state;
  logic [MATCH_W-1:0]       r_match_cnt;
  logic [STREAK_W-1:0]      r_streak;
  logic [ADDR_WIDTH-1:0]    r_chk_idx;
  logic [DATA_WIDTH-1:0]    r_chk_cnt;
  logic [PRBS_LEN-1:0]      r_chk_prbs;
  logic                     r_lock;
  logic                     r_error;
  logic [ERR_CNT_WIDTH-1:0] r_err_count;
  logic [31:0]              r_word_count;

  logic                  w_active;
  logic                  w_restart;
  logic [ADDR_WIDTH-1:0] w_gen_idx;
  logic [DATA_WIDTH-1:0] w_gen_cnt;
  logic [PRBS_LEN-1:0]   w_gen_prbs_cur;
  logic [DATA_WIDTH-1:0] w_gen_prbs_data;
  logic [PRBS_LEN-1:0]   w_gen_prbs_next;
  logic [DATA_WIDTH-1:0] w_chk_prbs_data;
  logic [PRBS_LEN-1:0]   w_chk_prbs_next;
  logic [DATA_WIDTH-1:0] w_chk_exp;
  logic                  w_is_data;
  logic                  w_match;
  logic                  w_hunt_hit;
  logic [ADDR_WIDTH-1:0] w_hunt_idx;
  logic [PRBS_LEN-1:0]   w_seed;
  logic [1:0]            w_st_nxt;
  logic [MATCH_W-1:0]    w_match_nxt;
  logic [STREAK_W-1:0]   w_streak_nxt;
  logic [ADDR_WIDTH-1:0] w_idx_nxt;
  logic [DATA_WIDTH-1:0] w_cnt_nxt;
  logic [PRBS_LEN-1:0]   w_prbs_nxt;
  logic                  w_advance;
  logic                  w_err_evt;
  logic                  w_word_evt;

  assign w_active  = cfg_enable && (cfg_mode != MODE_IDLE);
  assign w_restart = (cfg_mode != r_prev_mode) || (r_prev_enable && !cfg_enable);

  // While inactive the generator state sits at its seeds, so a restart only
  // has to override the registers on the cycle the mode changes.
  assign w_gen_idx      = w_restart ? '0 : r_gen_idx;
  assign w_gen_cnt      = w_restart ? '0 : r_gen_cnt;
  assign w_gen_prbs_cur = w_restart ? '1 : r_gen_prbs;

  eth_pattern_prbs31 #(.DATA_WIDTH(DATA_WIDTH)) u_gen_prbs (
    .i_state (w_gen_prbs_cur),
    .o_data  (w_gen_prbs_data),
    .o_state (w_gen_prbs_next)
  );

  eth_pattern_prbs31 #(.DATA_WIDTH(DATA_WIDTH)) u_chk_prbs (
    .i_state (r_chk_prbs),
    .o_data  (w_chk_prbs_data),
    .o_state (w_chk_prbs_next)
  );

  // Pattern table: preload on reset, single write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PATTERN_DEPTH; i++) r_table[i] <= {CTRL_WIDTH{preload_byte(i)}};
    end else if (cfg_pat_wr_en) begin
      r_table[cfg_pat_wr_addr] <= cfg_pat_wr_data;
    end
  end

  // Previous config, for restart detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev_mode   <= MODE_IDLE;
      r_prev_enable <= 1'b0;
    end else begin
      r_prev_mode   <= cfg_mode;
      r_prev_enable <= cfg_enable;
    end
  end

  // Generator: one word per cycle in the selected mode, IDLE otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_txd <= IDLE_WORD; r_txc <= '1;
      r_gen_idx <= '0; r_gen_cnt <= '0; r_gen_prbs <= '1;
    end else if (!w_active) begin
      r_txd <= IDLE_WORD; r_txc <= '1;
      r_gen_idx <= '0; r_gen_cnt <= '0; r_gen_prbs <= '1;
    end else begin
      r_txc <= '0;
      case (cfg_mode)
        MODE_TABLE: begin
          r_txd     <= r_table[w_gen_idx];
          r_gen_idx <= f_idx_next(w_gen_idx, cfg_pat_last);
        end
        MODE_COUNTER: begin
          r_txd     <= w_gen_cnt;
          r_gen_cnt <= w_gen_cnt + DATA_WIDTH'(1);
        end
        default: begin
          r_txd      <= w_gen_prbs_data;
          r_gen_prbs <= w_gen_prbs_next;
        end
      endcase
    end
  end

  // Expected word for the checker and match decode
  always_comb begin
    case (cfg_mode)
      MODE_TABLE:   w_chk_exp = r_table[r_chk_idx];
      MODE_COUNTER: w_chk_exp = r_chk_cnt;
      default:      w_chk_exp = w_chk_prbs_data;
    endcase
  end

  assign w_is_data = (xgmii_rxc == '0);
  assign w_match   = w_is_data && (xgmii_rxd == w_chk_exp);

  // Table sync: lowest in-use index holding the received word
  always_comb begin
    w_hunt_hit = 1'b0;
    w_hunt_idx = '0;
    for (int i = PATTERN_DEPTH - 1; i >= 0; i--) begin
      if ((ADDR_WIDTH'(i) <= cfg_pat_last) && (r_table[i] == xgmii_rxd)) begin
        w_hunt_hit = 1'b1;
        w_hunt_idx = ADDR_WIDTH'(i);
      end
    end
  end

  // PRBS sync: the last 31 bits of a word are the LFSR state that follows it
  always_comb begin
    w_seed = '0;
    for (int k = 0; k < PRBS_LEN; k++) w_seed[k] = xgmii_rxd[DATA_WIDTH-1-k];
  end

  // Checker next-state logic
  always_comb begin
    w_st_nxt     = r_chk_state;
    w_match_nxt  = r_match_cnt;
    w_streak_nxt = r_streak;
    w_idx_nxt    = r_chk_idx;
    w_cnt_nxt    = r_chk_cnt;
    w_prbs_nxt   = r_chk_prbs;
    w_advance    = 1'b0;
    w_err_evt    = 1'b0;
    w_word_evt   = 1'b0;
    if (!w_active || w_restart) begin
      w_st_nxt     = CHK_HUNT;
      w_match_nxt  = '0;
      w_streak_nxt = '0;
    end else begin
      case (r_chk_state)
        CHK_HUNT: begin
          if (w_is_data) begin
            w_match_nxt = '0;
            case (cfg_mode)
              MODE_TABLE: begin
                if (w_hunt_hit) begin
                  w_idx_nxt = f_idx_next(w_hunt_idx, cfg_pat_last);
                  w_st_nxt  = CHK_VERIFY;
                end
              end
              MODE_COUNTER: begin
                w_cnt_nxt = xgmii_rxd + DATA_WIDTH'(1);
                w_st_nxt  = CHK_VERIFY;
              end
              default: begin
                w_prbs_nxt = w_seed;
                w_st_nxt   = CHK_VERIFY;
              end
            endcase
          end
        end
        CHK_VERIFY: begin
          if (w_is_data) begin
            if (w_match) begin
              w_advance   = 1'b1;
              w_match_nxt = r_match_cnt + MATCH_W'(1);
              if (w_match_nxt == MATCH_W'(LOCK_MATCHES)) begin
                w_st_nxt     = CHK_LOCKED;
                w_streak_nxt = '0;
              end
            end else begin
              w_st_nxt = CHK_HUNT;
            end
          end
        end
        CHK_LOCKED: begin
          w_advance  = 1'b1;
          w_word_evt = 1'b1;
          if (w_match) begin
            w_streak_nxt = '0;
          end else begin
            w_err_evt    = 1'b1;
            w_streak_nxt = r_streak + STREAK_W'(1);
            if (w_streak_nxt == STREAK_W'(UNLOCK_ERRORS)) begin
              w_st_nxt    = CHK_HUNT;
              w_match_nxt = '0;
            end
          end
        end
        default: w_st_nxt = CHK_HUNT;
      endcase
      if (w_advance) begin
        case (cfg_mode)
          MODE_TABLE:   w_idx_nxt  = f_idx_next(r_chk_idx, cfg_pat_last);
          MODE_COUNTER: w_cnt_nxt  = r_chk_cnt + DATA_WIDTH'(1);
          default:      w_prbs_nxt = w_chk_prbs_next;
        endcase
      end
    end
  end

  // Checker registers, status outputs and saturating counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_chk_state  <= CHK_HUNT;
      r_match_cnt  <= '0;
      r_streak     <= '0;
      r_chk_idx    <= '0;
      r_chk_cnt    <= '0;
      r_chk_prbs   <= '1;
      r_lock       <= 1'b0;
      r_error      <= 1'b0;
      r_err_count  <= '0;
      r_word_count <= '0;
    end else begin
      r_chk_state <= w_st_nxt;
      r_match_cnt <= w_match_nxt;
      r_streak    <= w_streak_nxt;
      r_chk_idx   <= w_idx_nxt;
      r_chk_cnt   <= w_cnt_nxt;
      r_chk_prbs  <= w_prbs_nxt;
      r_lock      <= (w_st_nxt == CHK_LOCKED);
      r_error     <= w_err_evt;
      if (cfg_clear) begin
        r_err_count  <= '0;
        r_word_count <= '0;
      end else begin
        if (w_err_evt && (r_err_count != '1)) r_err_count <= r_err_count + ERR_CNT_WIDTH'(1);
        if (w_word_evt && (r_word_count != '1)) r_word_count <= r_word_count + 32'd1;
      end
    end
  end

  assign xgmii_txd       = r_txd;
  assign xgmii_txc       = r_txc;
  assign chk_lock        = r_lock;
  assign chk_error       = r_error;
  assign chk_error_count = r_err_count;
  assign chk_word_count  = r_word_count;

endmodule

// File: tb/tb_eth_pattern_gen_chk.sv
// Directed bench: generator output, loopback lock, error injection, clear and saturation.
module tb_eth_pattern_gen_chk;

  localparam int DW = 64;
  localparam int CW = 8;
  localparam int AW = 3;
  localparam int EW = 4;
  localparam logic [DW-1:0] IDLE_W = 64'h0707_0707_0707_0707;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_enable;
  logic [1:0]    cfg_mode;
  logic [AW-1:0] cfg_pat_last;
  logic          cfg_pat_wr_en;
  logic [AW-1:0] cfg_pat_wr_addr;
  logic [DW-1:0] cfg_pat_wr_data;
  logic          cfg_clear;
  logic [DW-1:0] xgmii_txd;
  logic [CW-1:0] xgmii_txc;
  logic [DW-1:0] xgmii_rxd;
  logic [CW-1:0] xgmii_rxc;
  logic          chk_lock;
  logic          chk_error;
  logic [EW-1:0] chk_error_count;
  logic [31:0]   chk_word_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [71:0]   p0, p1, p2;
  logic          force_zero, flip_once, alt_flip, alt_ph, last_flipped;
  logic [DW-1:0] exp_tab [6];

  always #5 clk = ~clk;

  eth_pattern_gen_chk #(
    .DATA_WIDTH(DW), .PATTERN_DEPTH(8), .LOCK_MATCHES(8),
    .UNLOCK_ERRORS(4), .ERR_CNT_WIDTH(EW)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_enable(cfg_enable), .cfg_mode(cfg_mode), .cfg_pat_last(cfg_pat_last),
    .cfg_pat_wr_en(cfg_pat_wr_en), .cfg_pat_wr_addr(cfg_pat_wr_addr),
    .cfg_pat_wr_data(cfg_pat_wr_data), .cfg_clear(cfg_clear),
    .xgmii_txd(xgmii_txd), .xgmii_txc(xgmii_txc),
    .xgmii_rxd(xgmii_rxd), .xgmii_rxc(xgmii_rxc),
    .chk_lock(chk_lock), .chk_error(chk_error),
    .chk_error_count(chk_error_count), .chk_word_count(chk_word_count)
  );

  // One clock: sample 1 time unit after the edge, then shift the 3-stage loopback
  task automatic tick();
    @(posedge clk);
    #1;
    p2 = p1;
    p1 = p0;
    p0 = {xgmii_txc, xgmii_txd};
    xgmii_rxc = p2[71:64];
    xgmii_rxd = p2[63:0];
    last_flipped = 1'b0;
    if (force_zero) begin
      xgmii_rxd = '0;
      xgmii_rxc = '0;
    end
    if (flip_once) begin
      xgmii_rxd[0] = ~xgmii_rxd[0];
      flip_once = 1'b0;
      last_flipped = 1'b1;
    end
    if (alt_flip) begin
      alt_ph = ~alt_ph;
      if (alt_ph) begin
        xgmii_rxd[0] = ~xgmii_rxd[0];
        last_flipped = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cfg_enable = 1'b0; cfg_mode = 2'd0; cfg_pat_last = 3'd5;
    cfg_pat_wr_en = 1'b0; cfg_pat_wr_addr = '0; cfg_pat_wr_data = '0; cfg_clear = 1'b0;
    force_zero = 1'b0; flip_once = 1'b0; alt_flip = 1'b0; alt_ph = 1'b0; last_flipped = 1'b0;
    p0 = {8'hFF, IDLE_W}; p1 = p0; p2 = p0;
    xgmii_rxd = IDLE_W; xgmii_rxc = 8'hFF;
    #12;
    n_cmp++; if (xgmii_txd !== IDLE_W) begin n_bad++; $display("FAIL rst_txd: got %h want %h", xgmii_txd, IDLE_W); end
    n_cmp++; if (xgmii_txc !== 8'hFF) begin n_bad++; $display("FAIL rst_txc: got %h want ff", xgmii_txc); end
    n_cmp++; if (chk_lock !== 1'b0) begin n_bad++; $display("FAIL rst_lock: got %b want 0", chk_lock); end
    n_cmp++; if (chk_error !== 1'b0) begin n_bad++; $display("FAIL rst_error: got %b want 0", chk_error); end
    n_cmp++; if (chk_error_count !== 4'd0) begin n_bad++; $display("FAIL rst_errcnt: got %0d want 0", chk_error_count); end
    n_cmp++; if (chk_word_count !== 32'd0) begin n_bad++; $display("FAIL rst_wordcnt: got %0d want 0", chk_word_count); end
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (xgmii_txd !== IDLE_W) begin n_bad++; $display("FAIL dis_txd: got %h want %h", xgmii_txd, IDLE_W); end
  endtask

  task automatic test_table();
    exp_tab[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_tab[1] = 64'h0000_0000_0000_0000;
    exp_tab[2] = 64'h5555_5555_5555_5555;
    exp_tab[3] = 64'hAAAA_AAAA_AAAA_AAAA;
    exp_tab[4] = 64'hFEFE_FEFE_FEFE_FEFE;
    exp_tab[5] = 64'h0707_0707_0707_0707;
    cfg_pat_last = 3'd5;
    cfg_mode = 2'd1;
    cfg_enable = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k <= 12) begin
        n_cmp++;
        if (xgmii_txd !== exp_tab[(k-1) % 6]) begin
          n_bad++; $display("FAIL tbl_txd[%0d]: got %h want %h", k, xgmii_txd, exp_tab[(k-1) % 6]);
        end
      end
      if (k == 1) begin
        n_cmp++; if (xgmii_txc !== 8'h00) begin n_bad++; $display("FAIL tbl_txc: got %h want 00", xgmii_txc); end
      end
      if (k == 11) begin
        n_cmp++; if (chk_lock !== 1'b0) begin n_bad++; $display("FAIL tbl_lock_early: got %b want 0", chk_lock); end
      end
      if (k == 12) begin
        n_cmp++; if (chk_lock !== 1'b1) begin n_bad++; $display("FAIL tbl_lock: got %b want 1", chk_lock); end
      end
    end
    n_cmp++; if (chk_error_count !== 4'd0) begin n_bad++; $display("FAIL tbl_errcnt: got %0d want 0", chk_error_count); end
    n_cmp++; if (chk_word_count !== 32'd8) begin n_bad++; $display("FAIL tbl_wordcnt: got %0d want 8", chk_word_count); end
  endtask

  task automatic test_mode_switch();
    int w;
    cfg_mode = 2'd2;
    tick();
    n_cmp++; if (chk_lock !== 1'b0) begin n_bad++; $display("FAIL sw_lock_drop: got %b want 0", chk_lock); end
    n_cmp++; if (xgmii_txd !== 64'd0) begin n_bad++; $display("FAIL sw_txd0: got %h want 0", xgmii_txd); end
    n_cmp++; if (chk_word_count !== 32'd8) begin n_bad++; $display("FAIL sw_wordcnt_kept: got %0d want 8", chk_word_count); end
    tick();
    n_cmp++; if (xgmii_txd !== 64'd1) begin n_bad++; $display("FAIL sw_txd1: got %h want 1", xgmii_txd); end
    tick();
    n_cmp++; if (xgmii_txd !== 64'd2) begin n_bad++; $display("FAIL sw_txd2: got %h want 2", xgmii_txd); end
    w = 0;
    while (chk_lock !== 1'b1 && w < 30) begin tick(); w++; end
    n_cmp++; if (chk_lock !== 1'b1) begin n_bad++; $display("FAIL sw_relock: got %b want 1 within 30 cycles", chk_lock); end
    n_cmp++; if (chk_error_count !== 4'd0) begin n_bad++; $display("FAIL sw_errcnt: got %0d want 0", chk_error_count); end
  endtask

  task automatic test_counter_flip();
    int pulses;
    flip_once = 1'b1;
    tick();
    n_cmp++; if (chk_error !== 1'b0) begin n_bad++; $display("FAIL flip_pre: got %b want 0", chk_error); end
    tick();
    n_cmp++; if (chk_error !== 1'b1) begin n_bad++; $display("FAIL flip_pulse: got %b want 1", chk_error); end
    n_cmp++; if (chk_error_count !== 4'd1) begin n_bad++; $display("FAIL flip_errcnt: got %0d want 1", chk_error_count); end
    n_cmp++; if (chk_lock !== 1'b1) begin n_bad++; $display("FAIL flip_lock: got %b want 1", chk_lock); end
    pulses = 0;
    repeat (5) begin tick(); if (chk_error === 1'b1) pulses++; end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL flip_extra_pulses: got %0d want 0", pulses); end
    n_cmp++; if (chk_error_count !== 4'd1) begin n_bad++; $display("FAIL flip_errcnt_after: got %0d want 1", chk_error_count); end
  endtask

  task automatic test_prbs_stuck();
    int w;
    cfg_mode = 2'd3;
    tick();
    n_cmp++; if (xgmii_txd !== 64'h3F00_0000_7000_0000) begin n_bad++; $display("FAIL prbs_first: got %h want 3f00000070000000", xgmii_txd); end
    w = 0;
    while (chk_lock !== 1'b1 && w < 40) begin tick(); w++; end
    n_cmp++; if (chk_lock !== 1'b1) begin n_bad++; $display("FAIL prbs_lock: got %b want 1 within 40 cycles", chk_lock); end
    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
    n_cmp++; if (chk_error_count !== 4'd0) begin n_bad++; $display("FAIL prbs_clr_err: got %0d want 0", chk_error_count); end
    n_cmp++; if (chk_word_count !== 32'd0) begin n_bad++; $display("FAIL prbs_clr_word: got %0d want 0", chk_word_count); end
    force_zero = 1'b1;
    repeat (4) tick();
    force_zero = 1'b0;
    n_cmp++; if (chk_error_count !== 4'd3) begin n_bad++; $display("FAIL stuck_errcnt3: got %0d want 3", chk_error_count); end
    n_cmp++; if (chk_lock !== 1'b1) begin n_bad++; $display("FAIL stuck_lock3: got %b want 1", chk_lock); end
    n_cmp++; if (chk_word_count !== 32'd4) begin n_bad++; $display("FAIL stuck_wordcnt: got %0d want 4", chk_word_count); end
    tick();
    n_cmp++; if (chk_error_count !== 4'd4) begin n_bad++; $display("FAIL stuck_errcnt4: got %0d want 4", chk_error_count); end
    n_cmp++; if (chk_lock !== 1'b0) begin n_bad++; $display("FAIL stuck_unlock: got %b want 0", chk_lock); end
    w = 0;
    while (chk_lock !== 1'b1 && w < 40) begin tick(); w++; end
    n_cmp++; if (chk_lock !== 1'b1) begin n_bad++; $display("FAIL stuck_relock: got %b want 1 within 40 cycles", chk_lock); end
    n_cmp++; if (chk_error_count !== 4'd4) begin n_bad++; $display("FAIL stuck_errcnt_after: got %0d want 4", chk_error_count); end
  endtask

  task automatic test_clear_saturate();
    int w;
    alt_flip = 1'b1;
    alt_ph = 1'b0;
    repeat (40) tick();
    n_cmp++; if (chk_error_count !== 4'd15) begin n_bad++; $display("FAIL sat_errcnt: got %0d want 15", chk_error_count); end
    n_cmp++; if (chk_lock !== 1'b1) begin n_bad++; $display("FAIL sat_lock: got %b want 1", chk_lock); end
    w = 0;
    while (last_flipped !== 1'b1 && w < 3) begin tick(); w++; end
    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
    n_cmp++; if (chk_error !== 1'b1) begin n_bad++; $display("FAIL clr_pulse: got %b want 1", chk_error); end
    n_cmp++; if (chk_error_count !== 4'd0) begin n_bad++; $display("FAIL clr_errcnt: got %0d want 0", chk_error_count); end
    n_cmp++; if (chk_word_count !== 32'd0) begin n_bad++; $display("FAIL clr_wordcnt: got %0d want 0", chk_word_count); end
    tick();
    n_cmp++; if (chk_error !== 1'b0) begin n_bad++; $display("FAIL clr_next_pulse: got %b want 0", chk_error); end
    n_cmp++; if (chk_word_count !== 32'd1) begin n_bad++; $display("FAIL clr_next_word: got %0d want 1", chk_word_count); end
    tick();
    n_cmp++; if (chk_error_count !== 4'd1) begin n_bad++; $display("FAIL clr_recount: got %0d want 1", chk_error_count); end
    alt_flip = 1'b0;
  endtask

  initial begin
    test_reset();
    test_table();
    test_mode_switch();
    test_counter_flip();
    test_prbs_stuck();
    test_clear_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
